// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared types and constants for the MEM-stage load/store unit
package rv_mem_pkg;

    typedef enum logic [1:0] {
        WIDTH_WORD   = 2'b00,
        WIDTH_HALF   = 2'b01,
        WIDTH_BYTE   = 2'b10,
        WIDTH_DOUBLE = 2'b11
    } width_t;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t S_IDLE  = 2'd0;
    localparam lsu_state_t S_BEAT0 = 2'd1;
    localparam lsu_state_t S_BEAT1 = 2'd2;
    localparam lsu_state_t S_DONE  = 2'd3;

    localparam logic [3:0] CAUSE_LOAD_MIS    = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

    function automatic logic [3:0] width_bytes(input width_t w);
        case (w)
            WIDTH_BYTE:   width_bytes = 4'd1;
            WIDTH_HALF:   width_bytes = 4'd2;
            WIDTH_WORD:   width_bytes = 4'd4;
            default:      width_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/rv_mem_lane_align.sv
// rtl/rv_mem_lane_align.sv - byte-lane masks, store rotation, load merge and extension
module rv_mem_lane_align
    import rv_mem_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OB = $clog2(NB)
) (
    input  width_t            width,
    input  logic [OB-1:0]     offset,
    input  logic              zero_ext,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata_lo,
    input  logic [XLEN-1:0]   rdata_hi,
    output logic [NB-1:0]     mask0,
    output logic [NB-1:0]     mask1,
    output logic [XLEN-1:0]   wdata_rot,
    output logic [XLEN-1:0]   rdata_ext
);

    logic [2*NB-1:0]   size_mask;
    logic [2*NB-1:0]   full_mask;
    logic [2*XLEN-1:0] rdata_cat;
    logic [XLEN-1:0]   merged;
    logic [3:0]        nbytes;

    // The two-word mask spans both beats; its upper half is beat1's lanes.
    always_comb begin
        nbytes    = width_bytes(width);
        size_mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes)) size_mask[i] = 1'b1;
        end
        full_mask = size_mask << offset;
        mask0     = full_mask[NB-1:0];
        mask1     = full_mask[2*NB-1:NB];
    end

    always_comb begin
        wdata_rot = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_rot[8*((i + int'(offset)) % NB) +: 8] = wdata[8*i +: 8];
        end
    end

    always_comb begin
        rdata_cat = {rdata_hi, rdata_lo};
        merged    = '0;
        for (int i = 0; i < NB; i++) begin
            merged[8*i +: 8] = rdata_cat[8*(i + int'(offset)) +: 8];
        end
        case (width)
            WIDTH_BYTE: rdata_ext = zero_ext ? XLEN'(merged[7:0])  : XLEN'($signed(merged[7:0]));
            WIDTH_HALF: rdata_ext = zero_ext ? XLEN'(merged[15:0]) : XLEN'($signed(merged[15:0]));
            WIDTH_WORD: rdata_ext = zero_ext ? XLEN'(merged[31:0]) : XLEN'($signed(merged[31:0]));
            default:    rdata_ext = merged;
        endcase
    end

endmodule

// File: rtl/rv_mem_lsu.sv
// rtl/rv_mem_lsu.sv - MEM-stage load/store unit with wait states, split beats and access faults
module rv_mem_lsu
    import rv_mem_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SPLIT_MIS = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_in,
    input  logic              req_valid_in,
    input  logic              req_write_in,
    input  logic [1:0]        width_in,
    input  logic              zero_ext_in,
    input  logic [XLEN-1:0]   addr_in,
    input  logic [XLEN-1:0]   wdata_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [XLEN-1:0]   rdata_out,
    output logic              exc_out,
    output logic [3:0]        exc_cause_out,
    output logic              bus_valid_out,
    input  logic              bus_ready_in,
    output logic              bus_write_out,
    output logic [XLEN-1:0]   bus_addr_out,
    output logic [XLEN-1:0]   bus_wdata_out,
    output logic [XLEN/8-1:0] bus_mask_out,
    input  logic [XLEN-1:0]   bus_rdata_in,
    input  logic              bus_fault_in
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_t      state;
    logic [XLEN-1:0] addr_r, wdata_r, rbuf_r, rdata_r;
    width_t          width_r;
    logic            write_r, zext_r, two_r, exc_r, flushed_r;
    logic [3:0]      cause_r;
    logic [TW-1:0]   cnt;

    logic            req_go, illegal_in, mis_in, cross_in, exc_now, in_beat;
    logic [3:0]      size_in, off_in;
    logic [NB-1:0]   mask0, mask1;
    logic [XLEN-1:0] wdata_rot, rdata_ext, base_addr;

    assign size_in    = width_bytes(width_t'(width_in));
    assign off_in     = 4'(addr_in[OB-1:0]);
    assign illegal_in = (width_in == WIDTH_DOUBLE) && (XLEN == 32);
    assign mis_in     = illegal_in || ((off_in & (size_in - 4'd1)) != 4'd0);
    assign cross_in   = ({1'b0, off_in} + {1'b0, size_in}) > 5'(NB);
    assign exc_now    = illegal_in || (mis_in && (SPLIT_MIS == 0));
    assign req_go     = (state == S_IDLE) && req_valid_in && !flush_in;
    assign in_beat    = (state == S_BEAT0) || (state == S_BEAT1);
    assign base_addr  = {addr_r[XLEN-1:OB], {OB{1'b0}}};

    rv_mem_lane_align #(.XLEN(XLEN)) u_align (
        .width     (width_r),
        .offset    (addr_r[OB-1:0]),
        .zero_ext  (zext_r),
        .wdata     (wdata_r),
        .rdata_lo  ((state == S_BEAT1) ? rbuf_r : bus_rdata_in),
        .rdata_hi  (bus_rdata_in),
        .mask0     (mask0),
        .mask1     (mask1),
        .wdata_rot (wdata_rot),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_r    <= '0;
            wdata_r   <= '0;
            rbuf_r    <= '0;
            rdata_r   <= '0;
            width_r   <= WIDTH_WORD;
            write_r   <= 1'b0;
            zext_r    <= 1'b0;
            two_r     <= 1'b0;
            exc_r     <= 1'b0;
            flushed_r <= 1'b0;
            cause_r   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    flushed_r <= 1'b0;
                    cnt       <= '0;
                    if (req_go) begin
                        addr_r  <= addr_in;
                        wdata_r <= wdata_in;
                        width_r <= width_t'(width_in);
                        write_r <= req_write_in;
                        zext_r  <= zero_ext_in;
                        two_r   <= cross_in;
                        rdata_r <= '0;
                        exc_r   <= exc_now;
                        cause_r <= req_write_in ? CAUSE_STORE_MIS : CAUSE_LOAD_MIS;
                        state   <= exc_now ? S_DONE : S_BEAT0;
                    end
                end
                S_BEAT0, S_BEAT1: begin
                    if (flush_in) flushed_r <= 1'b1;
                    if (bus_ready_in) begin
                        cnt <= '0;
                        if (flush_in || flushed_r) begin
                            state <= S_IDLE;
                        end else if (bus_fault_in) begin
                            exc_r   <= 1'b1;
                            cause_r <= write_r ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                            state   <= S_DONE;
                        end else if ((state == S_BEAT0) && two_r) begin
                            rbuf_r <= bus_rdata_in;
                            state  <= S_BEAT1;
                        end else begin
                            rdata_r <= write_r ? '0 : rdata_ext;
                            state   <= S_DONE;
                        end
                    end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                        // Valid is withdrawn only here, when the slave never answered.
                        cnt     <= '0;
                        exc_r   <= 1'b1;
                        cause_r <= write_r ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                        state   <= (flush_in || flushed_r) ? S_IDLE : S_DONE;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_out      = req_go || in_beat;
    assign done_out      = (state == S_DONE) && !flush_in;
    assign exc_out       = done_out && exc_r;
    assign exc_cause_out = exc_out ? cause_r : 4'd0;
    assign rdata_out     = done_out ? rdata_r : '0;
    assign bus_valid_out = in_beat;
    assign bus_write_out = in_beat && write_r;
    assign bus_addr_out  = (state == S_BEAT1) ? base_addr + XLEN'(NB) : (in_beat ? base_addr : '0);
    assign bus_wdata_out = in_beat ? wdata_rot : '0;
    assign bus_mask_out  = (state == S_BEAT0) ? mask0 : ((state == S_BEAT1) ? mask1 : '0);

endmodule

// File: tb/tb_rv_mem_lsu.sv
// tb/tb_rv_mem_lsu.sv - directed self-checking bench for rv_mem_lsu
module tb_rv_mem_lsu;

    logic        clk, reset, flush, write, zext, fault;
    logic [1:0]  width;
    logic [31:0] addr, wdata, bus_rdata;
    logic        req_a, ready_a, req_b, ready_b;
    logic        busy_a, done_a, exc_a, bv_a, bw_a;
    logic        busy_b, done_b, exc_b, bv_b, bw_b;
    logic [31:0] rdata_a, ba_a, bwd_a, rdata_b, ba_b, bwd_b;
    logic [3:0]  cause_a, cause_b, bm_a, bm_b;
    int          vectors = 0;
    int          miscompares = 0;

    rv_mem_lsu #(.XLEN(32), .SPLIT_MIS(1), .TIMEOUT(255)) dut_a (
        .clk(clk), .reset(reset), .flush_in(flush), .req_valid_in(req_a), .req_write_in(write),
        .width_in(width), .zero_ext_in(zext), .addr_in(addr), .wdata_in(wdata),
        .busy_out(busy_a), .done_out(done_a), .rdata_out(rdata_a), .exc_out(exc_a),
        .exc_cause_out(cause_a), .bus_valid_out(bv_a), .bus_ready_in(ready_a),
        .bus_write_out(bw_a), .bus_addr_out(ba_a), .bus_wdata_out(bwd_a), .bus_mask_out(bm_a),
        .bus_rdata_in(bus_rdata), .bus_fault_in(fault));

    rv_mem_lsu #(.XLEN(32), .SPLIT_MIS(0), .TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .flush_in(flush), .req_valid_in(req_b), .req_write_in(write),
        .width_in(width), .zero_ext_in(zext), .addr_in(addr), .wdata_in(wdata),
        .busy_out(busy_b), .done_out(done_b), .rdata_out(rdata_b), .exc_out(exc_b),
        .exc_cause_out(cause_b), .bus_valid_out(bv_b), .bus_ready_in(ready_b),
        .bus_write_out(bw_b), .bus_addr_out(ba_b), .bus_wdata_out(bwd_b), .bus_mask_out(bm_b),
        .bus_rdata_in(bus_rdata), .bus_fault_in(fault));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1; flush = 0; write = 0; zext = 0; fault = 0; width = 2'b00;
        addr = 0; wdata = 0; bus_rdata = 0; req_a = 0; ready_a = 0; req_b = 0; ready_b = 0;
        repeat (3) @(negedge clk);
        reset = 0; #1;
        vectors++; if (bv_a !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bv_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_a); end
        vectors++; if (rdata_a !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata_a); end
        vectors++; if (bm_b !== 4'h0) begin miscompares++; $display("FAIL reset_mask got %b want 0", bm_b); end
    endtask

    task automatic test_lw_aligned;
        @(negedge clk); req_a = 1; write = 0; width = 2'b00; addr = 32'h100; ready_a = 1; bus_rdata = 32'hDEADBEEF; #1;
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL lw_busy_accept got %b want 1", busy_a); end
        vectors++; if (bv_a !== 1'b0) begin miscompares++; $display("FAIL lw_valid_accept got %b want 0", bv_a); end
        @(negedge clk); req_a = 0; #1;
        vectors++; if (bv_a !== 1'b1) begin miscompares++; $display("FAIL lw_valid got %b want 1", bv_a); end
        vectors++; if (ba_a !== 32'h100) begin miscompares++; $display("FAIL lw_addr got %h want 100", ba_a); end
        vectors++; if (bm_a !== 4'b1111) begin miscompares++; $display("FAIL lw_mask got %b want 1111", bm_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL lw_early_done got %b want 0", done_a); end
        @(negedge clk); #1;
        vectors++; if (done_a !== 1'b1) begin miscompares++; $display("FAIL lw_done got %b want 1", done_a); end
        vectors++; if (rdata_a !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rdata got %h want deadbeef", rdata_a); end
        vectors++; if (exc_a !== 1'b0) begin miscompares++; $display("FAIL lw_exc got %b want 0", exc_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL lw_busy_done got %b want 0", busy_a); end
        @(negedge clk); #1;
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL lw_done_pulse got %b want 0", done_a); end
    endtask

    task automatic test_split(input string name, input logic [1:0] w, input logic [31:0] a, input logic ze,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [3:0] m0, input logic [3:0] m1,
                              input logic [31:0] exp);
        @(negedge clk); req_a = 1; write = 0; width = w; addr = a; zext = ze; ready_a = 1; #1;
        @(negedge clk); req_a = 0; bus_rdata = w0; #1;
        vectors++; if (ba_a !== a0) begin miscompares++; $display("FAIL %s_addr0 got %h want %h", name, ba_a, a0); end
        vectors++; if (bm_a !== m0) begin miscompares++; $display("FAIL %s_mask0 got %b want %b", name, bm_a, m0); end
        @(negedge clk); bus_rdata = w1; #1;
        vectors++; if (bv_a !== 1'b1 || ba_a !== a1) begin miscompares++; $display("FAIL %s_addr1 got %b/%h want 1/%h", name, bv_a, ba_a, a1); end
        vectors++; if (bm_a !== m1) begin miscompares++; $display("FAIL %s_mask1 got %b want %b", name, bm_a, m1); end
        @(negedge clk); #1;
        vectors++; if (done_a !== 1'b1 || rdata_a !== exp) begin miscompares++; $display("FAIL %s_rdata got %b/%h want 1/%h", name, done_a, rdata_a, exp); end
        zext = 0;
    endtask

    task automatic test_sb_wait;
        int ndone;
        @(negedge clk); req_a = 1; write = 1; width = 2'b10; addr = 32'h102; wdata = 32'h000000AB; ready_a = 0; #1;
        @(negedge clk); req_a = 0;
        for (int c = 0; c < 4; c++) begin
            ready_a = (c == 3); #1;
            vectors++; if (bv_a !== 1'b1 || bw_a !== 1'b1) begin miscompares++; $display("FAIL sb_hold_valid c%0d got %b%b want 11", c, bv_a, bw_a); end
            vectors++; if (ba_a !== 32'h100 || bm_a !== 4'b0100) begin miscompares++; $display("FAIL sb_hold_addr c%0d got %h/%b want 100/0100", c, ba_a, bm_a); end
            vectors++; if (bwd_a[23:16] !== 8'hAB) begin miscompares++; $display("FAIL sb_wdata c%0d got %h want ab", c, bwd_a[23:16]); end
            @(negedge clk);
        end
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            #1; if (done_a === 1'b1) ndone++;
            if (c == 0) begin
                vectors++; if (done_a !== 1'b1 || exc_a !== 1'b0) begin miscompares++; $display("FAIL sb_done got %b/%b want 1/0", done_a, exc_a); end
            end
            @(negedge clk);
        end
        vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL sb_done_count got %0d want 1", ndone); end
        write = 0;
    endtask

    task automatic test_misaligned;
        @(negedge clk); req_b = 1; write = 1; width = 2'b00; addr = 32'h101; #1;
        vectors++; if (busy_b !== 1'b1) begin miscompares++; $display("FAIL sw_mis_busy got %b want 1", busy_b); end
        @(negedge clk); req_b = 0; #1;
        vectors++; if (bv_b !== 1'b0) begin miscompares++; $display("FAIL sw_mis_valid got %b want 0", bv_b); end
        vectors++; if (done_b !== 1'b1 || exc_b !== 1'b1 || cause_b !== 4'd6) begin miscompares++; $display("FAIL sw_mis_exc got %b/%b/%0d want 1/1/6", done_b, exc_b, cause_b); end
        @(negedge clk); req_a = 1; write = 0; width = 2'b11; addr = 32'h100; ready_a = 1; #1;
        @(negedge clk); req_a = 0; #1;
        vectors++; if (bv_a !== 1'b0 || done_a !== 1'b1 || cause_a !== 4'd4) begin miscompares++; $display("FAIL ld_illegal got %b/%b/%0d want 0/1/4", bv_a, done_a, cause_a); end
        width = 2'b00;
    endtask

    task automatic test_timeout;
        int nvalid;
        @(negedge clk); req_b = 1; write = 0; width = 2'b00; addr = 32'h200; ready_b = 0; #1;
        @(negedge clk); req_b = 0;
        nvalid = 0;
        for (int c = 0; c < 4; c++) begin
            #1; if (bv_b === 1'b1) nvalid++;
            @(negedge clk);
        end
        #1;
        vectors++; if (nvalid !== 4) begin miscompares++; $display("FAIL timeout_valid_cycles got %0d want 4", nvalid); end
        vectors++; if (bv_b !== 1'b0) begin miscompares++; $display("FAIL timeout_drop got %b want 0", bv_b); end
        vectors++; if (done_b !== 1'b1 || cause_b !== 4'd5) begin miscompares++; $display("FAIL timeout_exc got %b/%0d want 1/5", done_b, cause_b); end
    endtask

    task automatic test_fault;
        @(negedge clk); req_a = 1; write = 0; width = 2'b00; addr = 32'h100; ready_a = 1; fault = 1; #1;
        @(negedge clk); req_a = 0; #1;
        @(negedge clk); #1;
        vectors++; if (done_a !== 1'b1 || exc_a !== 1'b1 || cause_a !== 4'd5) begin miscompares++; $display("FAIL lw_fault got %b/%b/%0d want 1/1/5", done_a, exc_a, cause_a); end
        @(negedge clk); req_a = 1; write = 1; addr = 32'h102; wdata = 32'h11223344; #1;
        @(negedge clk); req_a = 0; #1;
        vectors++; if (bm_a !== 4'b1100 || bwd_a !== 32'h33441122) begin miscompares++; $display("FAIL sw_split_beat0 got %b/%h want 1100/33441122", bm_a, bwd_a); end
        @(negedge clk); #1;
        vectors++; if (bv_a !== 1'b0 || done_a !== 1'b1 || cause_a !== 4'd7) begin miscompares++; $display("FAIL sw_fault_nobeat1 got %b/%b/%0d want 0/1/7", bv_a, done_a, cause_a); end
        fault = 0; write = 0;
    endtask

    task automatic test_flush;
        int ndone;
        @(negedge clk); req_a = 1; flush = 1; width = 2'b00; addr = 32'h100; #1;
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL flush_idle_busy got %b want 0", busy_a); end
        @(negedge clk); req_a = 0; flush = 0; #1;
        vectors++; if (bv_a !== 1'b0) begin miscompares++; $display("FAIL flush_idle_valid got %b want 0", bv_a); end
        @(negedge clk); req_a = 1; addr = 32'h102; ready_a = 0; #1;
        @(negedge clk); req_a = 0; flush = 1; #1;
        @(negedge clk); flush = 0; #1;
        vectors++; if (bv_a !== 1'b1 || ba_a !== 32'h100) begin miscompares++; $display("FAIL flush_beat_held got %b/%h want 1/100", bv_a, ba_a); end
        @(negedge clk); ready_a = 1; #1;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (done_a === 1'b1 || bv_a === 1'b1) ndone++;
        end
        vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL flush_no_beat1_done got %0d want 0", ndone); end
        @(negedge clk); req_a = 1; addr = 32'h100; #1;
        @(negedge clk); req_a = 0; #1;
        @(negedge clk); flush = 1; #1;
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL flush_done_suppress got %b want 0", done_a); end
        @(negedge clk); flush = 0; req_a = 1; ready_a = 0; #1;
        @(negedge clk); req_a = 0; #1;
        vectors++; if (bv_a !== 1'b1) begin miscompares++; $display("FAIL reset_mid_pre got %b want 1", bv_a); end
        @(negedge clk); reset = 1; #1;
        @(negedge clk); reset = 0; #1;
        vectors++; if (bv_a !== 1'b0 || busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_mid_beat got %b/%b want 0/0", bv_a, busy_a); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] t_addr [4] = '{32'h101, 32'h103, 32'h101, 32'h102};
        logic [1:0]  t_w    [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
        logic        t_ze   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_word [4] = '{32'h00008000, 32'hAB000000, 32'h00CDEF00, 32'h80010000};
        logic [3:0]  t_mask [4] = '{4'b0010, 4'b1000, 4'b0110, 4'b1100};
        logic [31:0] t_exp  [4] = '{32'hFFFFFF80, 32'h000000AB, 32'hFFFFCDEF, 32'h00008001};
        ready_a = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); req_a = 1; write = 0; addr = t_addr[k]; width = t_w[k]; zext = t_ze[k]; bus_rdata = t_word[k]; #1;
            @(negedge clk); req_a = 0; #1;
            vectors++; if (bm_a !== t_mask[k] || ba_a !== 32'h100) begin miscompares++; $display("FAIL b2b_beat%0d got %h/%b want 100/%b", k, ba_a, bm_a, t_mask[k]); end
            @(negedge clk); #1;
            vectors++; if (done_a !== 1'b1 || rdata_a !== t_exp[k]) begin miscompares++; $display("FAIL b2b_rdata%0d got %b/%h want 1/%h", k, done_a, rdata_a, t_exp[k]); end
        end
        zext = 0;
    endtask

    initial begin
        test_reset();
        test_lw_aligned();
        test_split("lh_split", 2'b01, 32'h103, 1'b0, 32'h80123456, 32'h1234567F, 32'h100, 32'h104, 4'b1000, 4'b0001, 32'h00007F80);
        test_split("lh_split_neg", 2'b01, 32'h103, 1'b0, 32'h7F000000, 32'h00000080, 32'h100, 32'h104, 4'b1000, 4'b0001, 32'hFFFF807F);
        test_split("lhu_split", 2'b01, 32'h103, 1'b1, 32'h7F000000, 32'h00000080, 32'h100, 32'h104, 4'b1000, 4'b0001, 32'h0000807F);
        test_split("lw_wrap", 2'b00, 32'hFFFFFFFE, 1'b0, 32'hBEEF0000, 32'h0000DEAD, 32'hFFFFFFFC, 32'h0, 4'b1100, 4'b0011, 32'hDEADBEEF);
        test_sb_wait();
        test_misaligned();
        test_timeout();
        test_fault();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
